// File: rtl/fp_alu_issuer_pkg.sv
// ------------------------------------------------------------------
// fp_alu_issuer_pkg : opcode, FP constant and flag definitions shared by the issuer
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package fp_alu_issuer_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_ABS = 4'd4;
  localparam logic [3:0] OP_NEG = 4'd5;
  localparam logic [3:0] OP_MIN = 4'd6;
  localparam logic [3:0] OP_MAX = 4'd7;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Response flag layout: {timeout, invalid, underflow, overflow}
  localparam logic [3:0] FLAGS_TIMEOUT = 4'b1000;
  localparam logic [3:0] FLAGS_INVALID = 4'b0100;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_alu_issuer_timer.sv
// ------------------------------------------------------------------
// fp_issue_timer : WAIT-phase counter with stale-done guard and saturating timeout
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module fp_issue_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic done,
  output logic done_seen,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wait_cnt <= '0;
    end else if (enable && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The first WAIT cycle ignores done: the ALU's registered done may be left over from the prior op.
  assign done_seen = enable && done && (wait_cnt != '0);
  // Raised on the cycle whose increment would bring the count to TIMEOUT_CYCLES.
  assign expired   = enable && (wait_cnt >= CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/fp_alu_issuer.sv
// ------------------------------------------------------------------
// fp_alu_issuer : single-outstanding command sequencer for the floating-point ALU
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module fp_alu_issuer
  import fp_alu_issuer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_op,
  output logic [31:0] alu_operand_a,
  output logic [31:0] alu_operand_b,
  output logic [3:0]  alu_operation,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  input  logic        alu_done,
  input  logic        alu_overflow,
  input  logic        alu_underflow,
  input  logic        alu_invalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  logic   issue_phase;
  logic   wait_phase;
  logic   done_seen;
  logic   expired;

  assign issue_phase = (state == ISSUE);
  assign wait_phase  = (state == WAIT);

  fp_issue_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (issue_phase),
    .enable    (wait_phase),
    .done      (alu_done),
    .done_seen (done_seen),
    .expired   (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_operation <= '0;
      alu_start     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            // Operands stay put until the next accept; the ALU output mux keys off operation.
            alu_operand_a <= cmd_a;
            alu_operand_b <= cmd_b;
            alu_operation <= cmd_op;
            cmd_ready     <= 1'b0;
            if (is_legal_op(cmd_op)) begin
              alu_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              rsp_valid  <= 1'b1;
              rsp_result <= FP_ZERO;
              rsp_flags  <= FLAGS_INVALID;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          alu_start <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // A done arriving on the expiry cycle takes precedence over the timeout.
          if (done_seen) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_flags  <= {1'b0, alu_invalid, alu_underflow, alu_overflow};
            state      <= RESP;
          end else if (expired) begin
            rsp_valid  <= 1'b1;
            rsp_result <= FP_QNAN;
            rsp_flags  <= FLAGS_TIMEOUT;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_alu_issuer.sv
// ------------------------------------------------------------------
// tb_fp_alu_issuer : directed vector bench for fp_alu_issuer with a behavioural ALU
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fp_alu_issuer;
  import fp_alu_issuer_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_op;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [3:0]  alu_operation;
  logic        alu_start;
  logic [31:0] alu_result;
  logic        alu_done = 1'b0;
  logic        alu_overflow;
  logic        alu_underflow;
  logic        alu_invalid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  always #5 clk = ~clk;

  fp_alu_issuer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_op        (cmd_op),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_operation (alu_operation),
    .alu_start     (alu_start),
    .alu_result    (alu_result),
    .alu_done      (alu_done),
    .alu_overflow  (alu_overflow),
    .alu_underflow (alu_underflow),
    .alu_invalid   (alu_invalid),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags)
  );

  // ALU model: mode 0 = done pulse model_delay cycles after start, 1 = never done, 2 = done stuck high
  int         model_mode  = 1;
  int         model_delay = 3;
  logic [3:0] mcnt        = 4'd0;
  logic       mbusy       = 1'b0;

  always @(posedge clk) begin
    if (model_mode == 2) begin
      alu_done <= 1'b1;
      mbusy    <= 1'b0;
    end else if (alu_start && model_mode == 0) begin
      if (model_delay <= 1) begin
        alu_done <= 1'b1;
        mbusy    <= 1'b0;
      end else begin
        alu_done <= 1'b0;
        mcnt     <= 4'(model_delay - 1);
        mbusy    <= 1'b1;
      end
    end else if (mbusy) begin
      if (mcnt == 4'd1) begin
        alu_done <= 1'b1;
        mbusy    <= 1'b0;
      end else begin
        alu_done <= 1'b0;
        mcnt     <= mcnt - 4'd1;
      end
    end else begin
      alu_done <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] mres;
    logic        minv;
    logic        munf;
    logic        movf;
    int          delay;   // 0 = ALU never answers
    logic [31:0] eres;
    logic [3:0]  eflags;
    int          elat;
    int          estarts;
  } vec_t;

  vec_t vecs[9];

  // Issues one command with rsp_ready high; lat is the cycle (relative to accept) where rsp_valid is first seen.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output int lat, output int starts, output int first_start,
                         output logic [31:0] res, output logic [3:0] flags, output int hold_bad);
    int guard;
    guard = 0; lat = -1; starts = 0; first_start = 0; hold_bad = 0; res = '0; flags = '0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (alu_start) begin
        starts++;
        if (first_start == 0) first_start = lat;
      end
      if (alu_operand_a !== a || alu_operand_b !== b || alu_operation !== op) hold_bad++;
      if (rsp_valid) break;
    end
    res   = rsp_result;
    flags = rsp_flags;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, starts, fst, hb, bad;
    logic [31:0] res;
    logic [3:0]  flags;

    vecs[0] = '{32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0, 1'b0, 1'b0, 3, 32'h40400000, 4'b0000,  5, 1};
    vecs[1] = '{32'h3F800000, 32'h00000000, OP_DIV, 32'h7F800000, 1'b1, 1'b0, 1'b0, 3, 32'h7F800000, 4'b0100,  5, 1};
    vecs[2] = '{32'h3F800000, 32'h40000000, 4'hA,   32'h11111111, 1'b0, 1'b0, 1'b0, 3, 32'h00000000, 4'b0100,  1, 0};
    vecs[3] = '{32'h7F7FFFFF, 32'hFF7FFFFF, OP_SUB, 32'h7F800000, 1'b0, 1'b0, 1'b1, 2, 32'h7F800000, 4'b0001,  4, 1};
    vecs[4] = '{32'h00800000, 32'h00800000, OP_MUL, 32'h00000000, 1'b0, 1'b1, 1'b0, 4, 32'h00000000, 4'b0010,  6, 1};
    vecs[5] = '{32'h3F800000, 32'h40000000, OP_DIV, 32'h12345678, 1'b0, 1'b0, 1'b0, 0, 32'h7FC00000, 4'b1000, 10, 1};
    vecs[6] = '{32'h40000000, 32'h40400000, OP_MAX, 32'h40400000, 1'b0, 1'b0, 1'b0, 8, 32'h40400000, 4'b0000, 10, 1};
    vecs[7] = '{32'h40000000, 32'h40400000, OP_MIN, 32'h40000000, 1'b0, 1'b0, 1'b0, 9, 32'h7FC00000, 4'b1000, 10, 1};
    vecs[8] = '{32'h3F800000, 32'h40000000, 4'hF,   32'h22222222, 1'b0, 1'b0, 1'b0, 3, 32'h00000000, 4'b0100,  1, 0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b1; alu_result = '0; alu_overflow = 1'b0; alu_underflow = 1'b0; alu_invalid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset_alu_start", {31'd0, alu_start}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_result", rsp_result, 32'd0);
    check("reset_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    check("reset_operand_a", alu_operand_a, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Table-driven commands
    for (int i = 0; i < 9; i++) begin
      model_mode    = (vecs[i].delay == 0) ? 1 : 0;
      model_delay   = vecs[i].delay;
      alu_result    = vecs[i].mres;
      alu_invalid   = vecs[i].minv;
      alu_underflow = vecs[i].munf;
      alu_overflow  = vecs[i].movf;
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, lat, starts, fst, res, flags, hb);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].elat));
      check($sformatf("v%0d_starts", i), 32'(starts), 32'(vecs[i].estarts));
      check($sformatf("v%0d_start_cycle", i), 32'(fst), 32'(vecs[i].estarts));
      check($sformatf("v%0d_result", i), res, vecs[i].eres);
      check($sformatf("v%0d_flags", i), {28'd0, flags}, {28'd0, vecs[i].eflags});
      check($sformatf("v%0d_operand_hold", i), 32'(hb), 32'd0);
    end

    // Stale done held high, with response backpressure and a queued command
    @(negedge clk);
    model_mode = 2; alu_result = 32'h3F800000;
    alu_invalid = 1'b0; alu_underflow = 1'b0; alu_overflow = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stale_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_a = 32'hBF800000; cmd_b = 32'h0; cmd_op = OP_ABS;
    @(posedge clk);
    #1;
    cmd_a = 32'h40A00000; cmd_op = OP_NEG;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("stale_latency", 32'(lat), 32'd4);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (!rsp_valid || rsp_result !== 32'h3F800000 || rsp_flags !== 4'b0000 ||
          cmd_ready || alu_operand_a !== 32'hBF800000 || alu_operation !== OP_ABS) bad++;
    end
    check("backpressure_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("handshake_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("handshake_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("queued_not_yet_taken", alu_operand_a, 32'hBF800000);
    alu_result = 32'hC0A00000;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("queued_accepted_a", alu_operand_a, 32'h40A00000);
    check("queued_accepted_op", {28'd0, alu_operation}, {28'd0, OP_NEG});
    check("queued_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    check("queued_latency", 32'(lat), 32'd4);
    check("queued_result", rsp_result, 32'hC0A00000);

    // Reset during WAIT abandons the operation
    @(negedge clk);
    model_mode = 1;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 32'h3F800000; cmd_b = 32'h40000000; cmd_op = OP_ADD;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_alu_start", {31'd0, alu_start}, 32'd0);
    check("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    model_mode = 0; model_delay = 3; alu_result = 32'h40C00000;
    run_cmd(32'h40000000, 32'h40400000, OP_MUL, lat, starts, fst, res, flags, hb);
    check("mul_latency", 32'(lat), 32'd5);
    check("mul_starts", 32'(starts), 32'd1);
    check("mul_result", res, 32'h40C00000);
    check("mul_flags", {28'd0, flags}, 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
